// File: rtl/memoredf_pkg.sv
// Shared types and helpers for the TDMA dispatcher slice.
package memoredf_pkg;

  typedef enum logic [0:0] {
    SERVE = 1'b0,
    GUARD = 1'b1
  } dispatch_state_t;

  // Queue id width never drops below one bit, even for a single queue.
  function automatic int queue_id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tdma_dispatcher_if.sv
// Bus bundle between the TDMA dispatcher and its environment (queues, scheduler, memory port).
interface tdma_dispatcher_if #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int COUNTER_WIDTH    = 32
) ();
  import memoredf_pkg::*;

  localparam int QID_W = queue_id_width(NUMBER_OF_QUEUES);

  logic [QID_W-1:0]                                selection;
  logic [NUMBER_OF_QUEUES-1:0]                     in_valid;
  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0]     in_data;
  logic [NUMBER_OF_QUEUES-1:0]                     in_ready;
  logic                                            out_valid;
  logic [DATA_WIDTH-1:0]                           out_data;
  logic [QID_W-1:0]                                out_queue;
  logic                                            out_ready;
  logic                                            slot_switch;
  logic [NUMBER_OF_QUEUES-1:0][COUNTER_WIDTH-1:0]  dispatch_count;
  logic [COUNTER_WIDTH-1:0]                        guard_count;

  modport master (
    output selection, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_queue, slot_switch,
           dispatch_count, guard_count
  );

  modport slave (
    input  selection, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_queue, slot_switch,
           dispatch_count, guard_count
  );

endinterface

// File: rtl/tdma_dispatcher_sat_counter.sv
// Saturating up-counter (sticks at all-ones) used for dispatcher statistics.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_r;

  // Count on inc until all-ones is reached.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_r <= {WIDTH{1'b0}};
    end else if (inc && (value_r != {WIDTH{1'b1}})) begin
      value_r <= value_r + WIDTH'(1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/tdma_dispatcher.sv
// TDMA dispatcher: serves only the slot owner, drains through a GUARD state at slot boundaries.
// Optional statistics counters are built when MEMOREDF_DISPATCH_STATS_EN is defined.
module tdma_dispatcher
  import memoredf_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int COUNTER_WIDTH    = 32
) (
  input  logic               clock,
  input  logic               reset,
  tdma_dispatcher_if.slave   bus
);

  localparam int QID_W = queue_id_width(NUMBER_OF_QUEUES);

  dispatch_state_t             state_r;
  dispatch_state_t             state_next_s;
  logic [QID_W-1:0]            active_q_r;
  logic [QID_W-1:0]            active_q_next_s;
  logic                        slot_switch_r;
  logic                        slot_switch_next_s;
  logic                        out_valid_r;
  logic [DATA_WIDTH-1:0]       out_data_r;
  logic [QID_W-1:0]            out_queue_r;
  logic                        accept_slot_s;
  logic                        owner_match_s;
  logic                        sel_in_range_s;
  logic                        grant_s;
  logic                        fire_s;
  logic [NUMBER_OF_QUEUES-1:0] in_ready_s;
  logic [NUMBER_OF_QUEUES-1:0] accept_vec_s;

  assign accept_slot_s  = !out_valid_r || bus.out_ready;
  assign owner_match_s  = (bus.selection == active_q_r);
  assign sel_in_range_s = (int'(bus.selection) < NUMBER_OF_QUEUES);
  assign grant_s        = (state_r == SERVE) && owner_match_s && accept_slot_s;
  assign accept_vec_s   = bus.in_valid & in_ready_s;
  assign fire_s         = |accept_vec_s;

  // Ready goes only to the active owner; gating by selection closes the port on the switch cycle.
  always_comb begin
    in_ready_s = {NUMBER_OF_QUEUES{1'b0}};
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      in_ready_s[i] = grant_s && (active_q_r == QID_W'(i));
    end
  end

  // Slot FSM next state: leave GUARD only once the output stage can take data and an owner exists.
  always_comb begin
    state_next_s       = state_r;
    active_q_next_s    = active_q_r;
    slot_switch_next_s = 1'b0;
    case (state_r)
      SERVE: begin
        if (!owner_match_s) begin
          state_next_s = GUARD;
        end else begin
          state_next_s = SERVE;
        end
      end
      GUARD: begin
        if (accept_slot_s && sel_in_range_s) begin
          state_next_s       = SERVE;
          active_q_next_s    = bus.selection;
          slot_switch_next_s = 1'b1;
        end else begin
          state_next_s = GUARD;
        end
      end
      default: begin
        state_next_s = SERVE;
      end
    endcase
  end

  // Slot FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= SERVE;
      active_q_r    <= {QID_W{1'b0}};
      slot_switch_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      active_q_r    <= active_q_next_s;
      slot_switch_r <= slot_switch_next_s;
    end
  end

  // Output stage: reload on accept, clear on consume, hold while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_queue_r <= {QID_W{1'b0}};
    end else if (fire_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= bus.in_data[active_q_r];
      out_queue_r <= active_q_r;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_queue_r <= out_queue_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_queue_r <= out_queue_r;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_queue   = out_queue_r;
  assign bus.slot_switch = slot_switch_r;

`ifdef MEMOREDF_DISPATCH_STATS_EN
  logic [NUMBER_OF_QUEUES-1:0][COUNTER_WIDTH-1:0] dispatch_count_s;
  logic [COUNTER_WIDTH-1:0]                       guard_count_s;

  for (genvar g = 0; g < NUMBER_OF_QUEUES; g++) begin : g_dispatch_cnt
    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_dispatch_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (accept_vec_s[g]),
      .value (dispatch_count_s[g])
    );
  end

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_guard_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (state_r == GUARD),
    .value (guard_count_s)
  );

  assign bus.dispatch_count = dispatch_count_s;
  assign bus.guard_count    = guard_count_s;
`else
  assign bus.dispatch_count = {(NUMBER_OF_QUEUES * COUNTER_WIDTH){1'b0}};
  assign bus.guard_count    = {COUNTER_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_tdma_dispatcher.sv
// Directed bench for tdma_dispatcher: stimulus pushes expected transfers, a monitor pops and compares.
module tb_tdma_dispatcher;

  localparam int NQ = 4;
  localparam int DW = 64;
  localparam int CW = 4;

  logic clock;
  logic reset;

  tdma_dispatcher_if #(.NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW)) bus ();

  tdma_dispatcher #(.NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    queue;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [1:0] q);
    exp_t e;
    e.data  = d;
    e.queue = q;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every downstream handshake must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got data 0x%0h queue %0d, expected no transfer",
                 bus.out_data, bus.out_queue);
      end else begin
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e.data);
        check("out_queue", {62'd0, bus.out_queue}, {62'd0, e.queue});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int waited;

    reset          = 1'b1;
    bus.selection  = 2'd0;
    bus.in_valid   = 4'b0000;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_queue", {62'd0, bus.out_queue}, 64'd0);
    check("rst_slot_switch", {63'd0, bus.slot_switch}, 64'd0);
    check("rst_guard_count", {60'd0, bus.guard_count}, 64'd0);
    tick();
    reset = 1'b0;

    // Test 1: owner 0 streams 0xA..0xD back to back.
    for (int k = 0; k < 4; k++) begin
      bus.in_valid   = 4'b0001;
      bus.in_data[0] = 64'(32'hA + k);
      push(64'(32'hA + k), 2'd0);
      @(negedge clock);
      check("t1_in_ready", {60'd0, bus.in_ready}, 64'h1);
      if (k > 0) check("t1_out_valid", {63'd0, bus.out_valid}, 64'd1);
      tick();
    end
    bus.in_valid = 4'b0000;
    @(negedge clock);
    check("t1_out_valid_last", {63'd0, bus.out_valid}, 64'd1);
    tick();
    @(negedge clock);
    check("t1_out_valid_empty", {63'd0, bus.out_valid}, 64'd0);
    tick();

    // Test 2: selection moves to idle queue 1 while queues 0 and 2 request.
    bus.selection  = 2'd1;
    bus.in_valid   = 4'b0101;
    bus.in_data[0] = 64'h0E;
    bus.in_data[2] = 64'h2E;
    @(negedge clock);
    check("t2_ready_switch", {60'd0, bus.in_ready}, 64'h0);
    check("t2_out_valid_a", {63'd0, bus.out_valid}, 64'd0);
    tick();
    @(negedge clock);
    check("t2_ready_guard", {60'd0, bus.in_ready}, 64'h0);
    check("t2_out_valid_b", {63'd0, bus.out_valid}, 64'd0);
    tick();
    @(negedge clock);
    check("t2_ready_owner1", {60'd0, bus.in_ready}, 64'h2);
    check("t2_slot_switch", {63'd0, bus.slot_switch}, 64'd1);
    check("t2_out_valid_c", {63'd0, bus.out_valid}, 64'd0);
    tick();
    @(negedge clock);
    check("t2_slot_switch_end", {63'd0, bus.slot_switch}, 64'd0);
    check("t2_out_valid_d", {63'd0, bus.out_valid}, 64'd0);
    tick();
    bus.in_valid = 4'b0000;

    // Test 3: stall across a 0->1 switch; GUARD holds until the output drains.
    bus.selection = 2'd0;
    repeat (3) tick();
    bus.in_valid   = 4'b0001;
    bus.in_data[0] = 64'h100;
    push(64'h100, 2'd0);
    @(negedge clock);
    check("t3_ready_q0", {60'd0, bus.in_ready}, 64'h1);
    tick();
    bus.out_ready  = 1'b0;
    bus.selection  = 2'd1;
    bus.in_data[0] = 64'h101;
    @(negedge clock);
    check("t3_ready_switch", {60'd0, bus.in_ready}, 64'h0);
    check("t3_out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t3_out_data", bus.out_data, 64'h100);
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("t3_stall_valid", {63'd0, bus.out_valid}, 64'd1);
      check("t3_stall_data", bus.out_data, 64'h100);
      check("t3_stall_queue", {62'd0, bus.out_queue}, 64'd0);
      check("t3_stall_switch", {63'd0, bus.slot_switch}, 64'd0);
      check("t3_stall_ready", {60'd0, bus.in_ready}, 64'h0);
      tick();
    end
    bus.out_ready  = 1'b1;
    bus.in_valid   = 4'b0010;
    bus.in_data[1] = 64'h200;
    @(negedge clock);
    check("t3_ready_drain", {60'd0, bus.in_ready}, 64'h0);
    tick();
    push(64'h200, 2'd1);
    @(negedge clock);
    check("t3_slot_switch", {63'd0, bus.slot_switch}, 64'd1);
    check("t3_ready_q1", {60'd0, bus.in_ready}, 64'h2);
    check("t3_out_valid_gap", {63'd0, bus.out_valid}, 64'd0);
    tick();
    bus.in_valid = 4'b0000;
    @(negedge clock);
    check("t3_switch_end", {63'd0, bus.slot_switch}, 64'd0);
    check("t3_out_valid_q1", {63'd0, bus.out_valid}, 64'd1);
    tick();

    // Test 4: selection 0->1->2 on consecutive cycles, output empty.
    bus.selection = 2'd0;
    repeat (3) tick();
    pulses = 0;
    bus.selection = 2'd1;
    @(negedge clock);
    pulses += int'(bus.slot_switch);
    check("t4_ready_sel1", {60'd0, bus.in_ready}, 64'h0);
    tick();
    bus.selection = 2'd2;
    @(negedge clock);
    pulses += int'(bus.slot_switch);
    tick();
    bus.in_valid   = 4'b0100;
    bus.in_data[2] = 64'h300;
    push(64'h300, 2'd2);
    @(negedge clock);
    pulses += int'(bus.slot_switch);
    check("t4_slot_switch", {63'd0, bus.slot_switch}, 64'd1);
    check("t4_ready_q2", {60'd0, bus.in_ready}, 64'h4);
    tick();
    bus.in_valid = 4'b0000;
    repeat (2) begin
      @(negedge clock);
      pulses += int'(bus.slot_switch);
      tick();
    end
    check("t4_pulse_count", 64'(pulses), 64'd1);

    // Test 5: reset while a transfer is stalled on the output.
    bus.in_valid   = 4'b0100;
    bus.in_data[2] = 64'h400;
    bus.out_ready  = 1'b0;
    @(negedge clock);
    check("t5_ready_q2", {60'd0, bus.in_ready}, 64'h4);
    tick();
    bus.in_valid = 4'b0000;
    @(negedge clock);
    check("t5_out_valid_stall", {63'd0, bus.out_valid}, 64'd1);
    check("t5_out_data_stall", bus.out_data, 64'h400);
    tick();
    reset         = 1'b1;
    bus.selection = 2'd0;
    tick();
    reset          = 1'b0;
    bus.out_ready  = 1'b1;
    bus.in_valid   = 4'b0001;
    bus.in_data[0] = 64'h4A0;
    @(negedge clock);
    check("t5_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t5_out_data", bus.out_data, 64'd0);
    check("t5_out_queue", {62'd0, bus.out_queue}, 64'd0);
    check("t5_slot_switch", {63'd0, bus.slot_switch}, 64'd0);
    check("t5_ready_q0", {60'd0, bus.in_ready}, 64'h1);
    check("t5_guard_count", {60'd0, bus.guard_count}, 64'd0);
    check("t5_dispatch_q2", {60'd0, bus.dispatch_count[2]}, 64'd0);
    bus.in_valid = 4'b0000;
    tick();

    // Test 6: 20 accepts from queue 3 saturate its 4-bit counter.
    bus.selection = 2'd3;
    repeat (3) tick();
    for (int k = 0; k < 20; k++) begin
      bus.in_valid   = 4'b1000;
      bus.in_data[3] = 64'(32'h500 + k);
      push(64'(32'h500 + k), 2'd3);
      @(negedge clock);
      check("t6_ready_q3", {60'd0, bus.in_ready}, 64'h8);
      tick();
    end
    bus.in_valid = 4'b0000;
    tick();
    @(negedge clock);
`ifdef MEMOREDF_DISPATCH_STATS_EN
    check("t6_dispatch_q3", {60'd0, bus.dispatch_count[3]}, 64'd15);
    check("t6_guard_count", {60'd0, bus.guard_count}, 64'd1);
`else
    check("t6_dispatch_q3", {60'd0, bus.dispatch_count[3]}, 64'd0);
    check("t6_guard_count", {60'd0, bus.guard_count}, 64'd0);
`endif
    check("t6_dispatch_q0", {60'd0, bus.dispatch_count[0]}, 64'd0);
    check("t6_dispatch_q1", {60'd0, bus.dispatch_count[1]}, 64'd0);
    check("t6_dispatch_q2", {60'd0, bus.dispatch_count[2]}, 64'd0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      tick();
      waited++;
    end
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tdma_dispatcher.md
Name: tdma_dispatcher

Overview:
Consumer side of the TDMA slot scheduler. It takes the scheduler's `selection` output and forwards requests from the per-queue valid/ready interfaces to a single downstream memory-request port. Only the queue owning the current slot is served. A registered output stage gives 1-cycle latency. A guard state drains in-flight data at every slot boundary, so no request from the old owner leaks into the new slot.

Parameters:
- NUMBER_OF_QUEUES, 4, number of requesting queues; must match the scheduler.
- DATA_WIDTH, 64, request payload width.
- COUNTER_WIDTH, 32, statistics counter width (used only with the optional feature).

Ports:
- clock  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- selection  in  $clog2(NUMBER_OF_QUEUES)  slot owner from the TDMA scheduler.
- in_valid  in  NUMBER_OF_QUEUES  per-queue request valid.
- in_data  in  NUMBER_OF_QUEUES x DATA_WIDTH  per-queue request payload.
- in_ready  out  NUMBER_OF_QUEUES  per-queue accept; combinational.
- out_valid  out  1  downstream request valid; registered.
- out_data  out  DATA_WIDTH  downstream payload; registered.
- out_queue  out  $clog2(NUMBER_OF_QUEUES)  source queue of out_data; registered.
- out_ready  in  1  downstream accept.
- slot_switch  out  1  one-cycle pulse when the active owner changes; registered.
- dispatch_count  out  NUMBER_OF_QUEUES x COUNTER_WIDTH  statistics output (see Optional Feature).
- guard_count  out  COUNTER_WIDTH  statistics output (see Optional Feature).

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_queue=0, slot_switch=0.
  - active_q=0, state=SERVE, all counters 0.
- Reset takes effect mid-transfer: a pending out_valid is dropped without handshake.
- Internal signal: accept_slot = !out_valid || out_ready.
- State SERVE:
  - in_ready[i] = (i==active_q) && (selection==active_q) && accept_slot.
  - All other in_ready bits are 0.
- Handshake on input: in_valid[i] && in_ready[i] → next cycle out_valid=1, out_data=in_data[i], out_queue=i.
- Output register update:
  - out_valid && out_ready with no new accept → out_valid=0 next cycle.
  - Accept and consume in the same cycle → register reloads; back-to-back throughput is 1 per cycle.
  - While out_valid && !out_ready, out_data and out_queue are held stable.
- SERVE → GUARD: when selection != active_q. In that cycle in_ready is already 0, because it is gated by selection.
- State GUARD:
  - in_ready = 0.
  - Stays in GUARD while out_valid && !out_ready.
  - When accept_slot is true and selection < NUMBER_OF_QUEUES: active_q <= selection, slot_switch pulses next cycle, state → SERVE.
- Minimum cost of a slot switch is 1 guard cycle.
- Selection out of range (>= NUMBER_OF_QUEUES, possible for non-power-of-2 counts): treated as no owner.
  - Stay in GUARD, or enter it if currently in SERVE.
  - Nothing is accepted.
- Selection changing again while in GUARD: the value sampled on the exit cycle wins. There is no history.
- in_valid of non-owner queues is ignored. Those queues must hold their requests; nothing is dropped.
- No combinational path from out_ready to out_valid/out_data. The only combinational path is out_ready → in_ready.

Optional Feature:
- Macro: MEMOREDF_DISPATCH_STATS_EN.
- Defined:
  - dispatch_count[i] increments on every accepted transfer from queue i.
  - guard_count increments on every cycle spent in GUARD.
  - Both saturate at all-ones (no wrap) and clear on reset.
- Undefined:
  - Both ports are present but driven constant 0.
  - No counter flops are instantiated.

Decomposition:
- memoredf_pkg holds:
  - typedef dispatch_state_t {SERVE, GUARD}.
  - function queue_id_width(n) returning $clog2(n), with a minimum of 1.
- Natural sub-module: sat_counter (parameter WIDTH; inputs clock, reset, inc; output value; saturating). Instantiated per queue and for guard_count under the macro.

Test Plan:
1. Reset, then selection=0, queue 0 in_valid held with data 0xA..0xD, out_ready=1 → in_ready[0]=1 every cycle; out_data sequence 0xA–0xD with 1-cycle latency; out_queue=0.
2. selection=1, queue 0 and queue 2 in_valid=1 → in_ready=4'b0000 for non-owners; no out_valid, since queue 1 is idle.
3. Owner 0 streaming, out_ready=0 with out_valid=1, selection switches 0→1 → GUARD held while stalled; out_data stable; after out_ready=1 for one cycle, slot_switch pulses, active_q=1, and queue 1 is accepted on the following cycle.
4. Selection 0→1→2 on consecutive cycles with the output empty → single GUARD cycle exits to active_q=2; exactly one slot_switch pulse.
5. Reset asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, active_q=0, state SERVE, counters 0.
6. With MEMOREDF_DISPATCH_STATS_EN and COUNTER_WIDTH=4, 20 accepts from queue 3 → dispatch_count[3]=15 (saturated), others 0. Without the macro, all counts stay 0.
